// File: rtl/cpu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : cpu_pkg
// Purpose: Shared CPU types for the execute front end: datapath widths, ALU
//          operation encoding, the ID->EX pipeline register layout and the
//          forwarding-match helper.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
package cpu_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'b0000,
      ALU_SUB   = 4'b1000,
      ALU_SLL   = 4'b0001,
      ALU_SLT   = 4'b0010,
      ALU_SLTU  = 4'b1010,
      ALU_PASSB = 4'b0011,
      ALU_XOR   = 4'b0100,
      ALU_SRL   = 4'b0101,
      ALU_SRA   = 4'b1101,
      ALU_OR    = 4'b0110,
      ALU_AND   = 4'b0111
   } alu_op_e;

   // Contents of the ID->EX pipeline register. alu_sel carries an alu_op_e
   // encoding as raw bits so that the register resets to ALU_ADD (all zero).
   typedef struct packed {
      logic              valid;
      logic [XLEN-1:0]   pc;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic [XLEN-1:0]   rs1_val;
      logic [XLEN-1:0]   rs2_val;
      logic [XLEN-1:0]   imm;
      logic [REG_AW-1:0] rd;
      logic [3:0]        alu_sel;
      logic              a_sel;
      logic              b_sel;
      logic              reg_we;
      logic              mem_re;
      logic              mem_we;
   } id_ex_t;

   // A producer supplies register rs only if it really writes and is not x0.
   function automatic logic fwd_hit(input logic              we,
                                    input logic [REG_AW-1:0] rd,
                                    input logic [REG_AW-1:0] rs);
      return we && (rd != '0) && (rd == rs);
   endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/id_ex_stage_fwd_mux.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : fwd_mux
// Purpose: Operand bypass for one EX source register. The younger EX/MEM
//          result beats the MEM/WB result, which beats the registered value.
// Ports  : i_rs                   source register address held in EX
//          i_reg_val              value captured in the ID->EX register
//          i_exmem_rd/_we/_result producer one stage ahead of EX
//          i_memwb_rd/_we/_result register-file write in progress
//          o_val                  forwarded operand
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module fwd_mux
   import cpu_pkg::*;
(
   input  logic [REG_AW-1:0] i_rs,
   input  logic [XLEN-1:0]   i_reg_val,
   input  logic [REG_AW-1:0] i_exmem_rd,
   input  logic              i_exmem_we,
   input  logic [XLEN-1:0]   i_exmem_result,
   input  logic [REG_AW-1:0] i_memwb_rd,
   input  logic              i_memwb_we,
   input  logic [XLEN-1:0]   i_memwb_result,
   output logic [XLEN-1:0]   o_val
);

   always_comb begin
      o_val = i_reg_val;
      if (fwd_hit(i_exmem_we, i_exmem_rd, i_rs)) begin
         o_val = i_exmem_result;
      end else if (fwd_hit(i_memwb_we, i_memwb_rd, i_rs)) begin
         o_val = i_memwb_result;
      end
   end

endmodule : fwd_mux
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : id_ex_stage
// Purpose: ID->EX pipeline register with operand forwarding, ALU input
//          muxing, load-use hazard detection and stall/flush handling.
// Ports  : clk, rst_n               clock, asynchronous active-low reset
//          i_stall, i_flush          hold EX / kill instruction entering EX
//          i_id_*                    decoded instruction from ID
//          i_exmem_*, i_memwb_*      in-flight results for bypassing
//          o_load_use_hazard         combinational: hold IF/ID this cycle
//          o_ex_*                    EX-stage instruction, operands, controls
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module id_ex_stage
   import cpu_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_stall,
   input  logic              i_flush,
   input  logic              i_id_valid,
   input  logic [XLEN-1:0]   i_id_pc,
   input  logic [REG_AW-1:0] i_id_rs1,
   input  logic [REG_AW-1:0] i_id_rs2,
   input  logic              i_id_use_rs1,
   input  logic              i_id_use_rs2,
   input  logic [XLEN-1:0]   i_id_rs1_data,
   input  logic [XLEN-1:0]   i_id_rs2_data,
   input  logic [XLEN-1:0]   i_id_imm,
   input  logic [REG_AW-1:0] i_id_rd,
   input  logic [3:0]        i_id_alu_sel,
   input  logic              i_id_a_sel,
   input  logic              i_id_b_sel,
   input  logic              i_id_reg_we,
   input  logic              i_id_mem_re,
   input  logic              i_id_mem_we,
   input  logic [REG_AW-1:0] i_exmem_rd,
   input  logic              i_exmem_we,
   input  logic [XLEN-1:0]   i_exmem_result,
   input  logic [REG_AW-1:0] i_memwb_rd,
   input  logic              i_memwb_we,
   input  logic [XLEN-1:0]   i_memwb_result,
   output logic              o_load_use_hazard,
   output logic              o_ex_valid,
   output logic [XLEN-1:0]   o_ex_alu_a,
   output logic [XLEN-1:0]   o_ex_alu_b,
   output logic [3:0]        o_ex_alu_sel,
   output logic [XLEN-1:0]   o_ex_store_data,
   output logic [XLEN-1:0]   o_ex_pc,
   output logic [XLEN-1:0]   o_ex_imm,
   output logic [REG_AW-1:0] o_ex_rd,
   output logic              o_ex_reg_we,
   output logic              o_ex_mem_re,
   output logic              o_ex_mem_we
);

   id_ex_t          r_ex;
   logic [XLEN-1:0] w_fwd_rs1;
   logic [XLEN-1:0] w_fwd_rs2;
   logic            w_load_use;

   fwd_mux u_fwd_rs1 (
      .i_rs           (r_ex.rs1),
      .i_reg_val      (r_ex.rs1_val),
      .i_exmem_rd     (i_exmem_rd),
      .i_exmem_we     (i_exmem_we),
      .i_exmem_result (i_exmem_result),
      .i_memwb_rd     (i_memwb_rd),
      .i_memwb_we     (i_memwb_we),
      .i_memwb_result (i_memwb_result),
      .o_val          (w_fwd_rs1)
   );

   fwd_mux u_fwd_rs2 (
      .i_rs           (r_ex.rs2),
      .i_reg_val      (r_ex.rs2_val),
      .i_exmem_rd     (i_exmem_rd),
      .i_exmem_we     (i_exmem_we),
      .i_exmem_result (i_exmem_result),
      .i_memwb_rd     (i_memwb_rd),
      .i_memwb_we     (i_memwb_we),
      .i_memwb_result (i_memwb_result),
      .o_val          (w_fwd_rs2)
   );

   // A load in EX cannot feed the instruction in ID in time; the consumer
   // waits one cycle and then picks the load data up from MEM/WB. A flush
   // discards the ID instruction anyway, so no hold is requested then.
   assign w_load_use = r_ex.valid && r_ex.mem_re && (r_ex.rd != '0) && i_id_valid
                       && ((i_id_use_rs1 && (i_id_rs1 == r_ex.rd))
                        || (i_id_use_rs2 && (i_id_rs2 == r_ex.rd)))
                       && !i_flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ex <= '0;
      end else if (i_flush) begin
         r_ex.valid  <= 1'b0;
         r_ex.reg_we <= 1'b0;
         r_ex.mem_re <= 1'b0;
         r_ex.mem_we <= 1'b0;
      end else if (i_stall) begin
         // Re-latch the bypassed operands: a producer may leave the
         // forwarding window while EX is frozen.
         r_ex.rs1_val <= w_fwd_rs1;
         r_ex.rs2_val <= w_fwd_rs2;
      end else if (w_load_use) begin
         r_ex.valid  <= 1'b0;
         r_ex.reg_we <= 1'b0;
         r_ex.mem_re <= 1'b0;
         r_ex.mem_we <= 1'b0;
      end else begin
         r_ex.valid   <= i_id_valid;
         r_ex.pc      <= i_id_pc;
         r_ex.rs1     <= i_id_rs1;
         r_ex.rs2     <= i_id_rs2;
         // The register file has no write-through, so a same-cycle write
         // is bypassed here at capture.
         r_ex.rs1_val <= fwd_hit(i_memwb_we, i_memwb_rd, i_id_rs1) ? i_memwb_result
                                                                   : i_id_rs1_data;
         r_ex.rs2_val <= fwd_hit(i_memwb_we, i_memwb_rd, i_id_rs2) ? i_memwb_result
                                                                   : i_id_rs2_data;
         r_ex.imm     <= i_id_imm;
         r_ex.rd      <= i_id_rd;
         r_ex.alu_sel <= i_id_alu_sel;
         r_ex.a_sel   <= i_id_a_sel;
         r_ex.b_sel   <= i_id_b_sel;
         r_ex.reg_we  <= i_id_reg_we && i_id_valid;
         r_ex.mem_re  <= i_id_mem_re && i_id_valid;
         r_ex.mem_we  <= i_id_mem_we && i_id_valid;
      end
   end

   assign o_load_use_hazard = w_load_use;
   assign o_ex_valid        = r_ex.valid;
   assign o_ex_alu_a        = r_ex.a_sel ? r_ex.pc  : w_fwd_rs1;
   assign o_ex_alu_b        = r_ex.b_sel ? r_ex.imm : w_fwd_rs2;
   assign o_ex_alu_sel      = r_ex.alu_sel;
   assign o_ex_store_data   = w_fwd_rs2;
   assign o_ex_pc           = r_ex.pc;
   assign o_ex_imm          = r_ex.imm;
   assign o_ex_rd           = r_ex.rd;
   assign o_ex_reg_we       = r_ex.reg_we;
   assign o_ex_mem_re       = r_ex.mem_re;
   assign o_ex_mem_we       = r_ex.mem_we;

endmodule : id_ex_stage
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_id_ex_stage
// Purpose: Self-checking bench for id_ex_stage: directed scenarios plus a
//          randomized run against a behavioural pipeline-register model.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, flush, id_valid;
   logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        id_use_rs1, id_use_rs2;
   logic [3:0]  id_alu_sel;
   logic        id_a_sel, id_b_sel, id_reg_we, id_mem_re, id_mem_we;
   logic [4:0]  exmem_rd, memwb_rd;
   logic        exmem_we, memwb_we;
   logic [31:0] exmem_result, memwb_result;
   logic        load_use_hazard, ex_valid;
   logic [31:0] ex_alu_a, ex_alu_b, ex_store_data, ex_pc, ex_imm;
   logic [3:0]  ex_alu_sel;
   logic [4:0]  ex_rd;
   logic        ex_reg_we, ex_mem_re, ex_mem_we;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .rst_n(rst_n), .i_stall(stall), .i_flush(flush),
      .i_id_valid(id_valid), .i_id_pc(id_pc), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
      .i_id_use_rs1(id_use_rs1), .i_id_use_rs2(id_use_rs2),
      .i_id_rs1_data(id_rs1_data), .i_id_rs2_data(id_rs2_data), .i_id_imm(id_imm),
      .i_id_rd(id_rd), .i_id_alu_sel(id_alu_sel), .i_id_a_sel(id_a_sel),
      .i_id_b_sel(id_b_sel), .i_id_reg_we(id_reg_we), .i_id_mem_re(id_mem_re),
      .i_id_mem_we(id_mem_we),
      .i_exmem_rd(exmem_rd), .i_exmem_we(exmem_we), .i_exmem_result(exmem_result),
      .i_memwb_rd(memwb_rd), .i_memwb_we(memwb_we), .i_memwb_result(memwb_result),
      .o_load_use_hazard(load_use_hazard), .o_ex_valid(ex_valid),
      .o_ex_alu_a(ex_alu_a), .o_ex_alu_b(ex_alu_b), .o_ex_alu_sel(ex_alu_sel),
      .o_ex_store_data(ex_store_data), .o_ex_pc(ex_pc), .o_ex_imm(ex_imm),
      .o_ex_rd(ex_rd), .o_ex_reg_we(ex_reg_we), .o_ex_mem_re(ex_mem_re),
      .o_ex_mem_we(ex_mem_we)
   );

   task automatic idle_inputs();
      stall = 0; flush = 0; id_valid = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0;
      id_use_rs1 = 0; id_use_rs2 = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
      id_rd = 0; id_alu_sel = 0; id_a_sel = 0; id_b_sel = 0; id_reg_we = 0;
      id_mem_re = 0; id_mem_we = 0; exmem_rd = 0; exmem_we = 0; exmem_result = 0;
      memwb_rd = 0; memwb_we = 0; memwb_result = 0;
   endtask

   // Register-register instruction reading rs1/rs2 and writing rd.
   task automatic present(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [31:0] d1, input logic [31:0] d2);
      id_valid = 1; id_pc = 32'h100; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
      id_use_rs1 = 1; id_use_rs2 = 1; id_rs1_data = d1; id_rs2_data = d2;
      id_imm = 0; id_alu_sel = 4'b0000; id_a_sel = 0; id_b_sel = 0;
      id_reg_we = 1; id_mem_re = 0; id_mem_we = 0;
   endtask

   task automatic test_reset();
      rst_n = 0; idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %0h want 0", ex_valid); end
      n_checks++; if (ex_alu_a !== 32'h0) begin n_err++; $display("FAIL rst_alu_a: got %0h want 0", ex_alu_a); end
      n_checks++; if (ex_alu_sel !== 4'b0000) begin n_err++; $display("FAIL rst_sel: got %0h want 0", ex_alu_sel); end
      n_checks++; if ({ex_reg_we, ex_mem_re, ex_mem_we} !== 3'b000) begin n_err++; $display("FAIL rst_ctrl: got %0b want 000", {ex_reg_we, ex_mem_re, ex_mem_we}); end
      n_checks++; if ({ex_pc, ex_imm, ex_rd} !== 69'h0) begin n_err++; $display("FAIL rst_fields: got %0h want 0", {ex_pc, ex_imm, ex_rd}); end
      n_checks++; if (load_use_hazard !== 1'b0) begin n_err++; $display("FAIL rst_hazard: got %0h want 0", load_use_hazard); end
      @(negedge clk); rst_n = 1;
   endtask

   task automatic test_capture();
      @(negedge clk); idle_inputs(); present(5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
      @(posedge clk); #1;
      n_checks++; if (ex_alu_a !== 32'd5) begin n_err++; $display("FAIL cap_a: got %0h want 5", ex_alu_a); end
      n_checks++; if (ex_alu_b !== 32'd7) begin n_err++; $display("FAIL cap_b: got %0h want 7", ex_alu_b); end
      n_checks++; if (ex_valid !== 1'b1) begin n_err++; $display("FAIL cap_valid: got %0h want 1", ex_valid); end
      n_checks++; if (ex_rd !== 5'd3 || ex_reg_we !== 1'b1) begin n_err++; $display("FAIL cap_rd: got %0h/%0h want 3/1", ex_rd, ex_reg_we); end
      idle_inputs();
   endtask

   task automatic test_fwd_priority();
      @(negedge clk); idle_inputs(); present(5'd1, 5'd2, 5'd4, 32'd1, 32'd2);
      @(posedge clk); #1;
      idle_inputs();
      exmem_we = 1; exmem_rd = 5'd1; exmem_result = 32'h10;
      memwb_we = 1; memwb_rd = 5'd1; memwb_result = 32'h20;
      #1;
      n_checks++; if (ex_alu_a !== 32'h10) begin n_err++; $display("FAIL fwd_exmem: got %0h want 10", ex_alu_a); end
      exmem_rd = 5'd0;
      #1;
      n_checks++; if (ex_alu_a !== 32'h20) begin n_err++; $display("FAIL fwd_memwb: got %0h want 20", ex_alu_a); end
      n_checks++; if (ex_alu_b !== 32'd2) begin n_err++; $display("FAIL fwd_b_reg: got %0h want 2", ex_alu_b); end
      idle_inputs();
      @(posedge clk);
   endtask

   task automatic test_load_use();
      @(negedge clk); idle_inputs();
      present(5'd1, 5'd0, 5'd5, 32'h0, 32'h0);
      id_use_rs2 = 0; id_mem_re = 1; id_b_sel = 1;
      @(posedge clk); #1;
      present(5'd5, 5'd0, 5'd6, 32'hDEAD, 32'h0);
      #1;
      n_checks++; if (load_use_hazard !== 1'b1) begin n_err++; $display("FAIL lu_hazard: got %0h want 1", load_use_hazard); end
      @(posedge clk); #1;
      n_checks++; if (ex_valid !== 1'b0 || ex_reg_we !== 1'b0 || ex_mem_re !== 1'b0) begin n_err++; $display("FAIL lu_bubble: got v=%0h we=%0h re=%0h want 0", ex_valid, ex_reg_we, ex_mem_re); end
      n_checks++; if (load_use_hazard !== 1'b0) begin n_err++; $display("FAIL lu_clear: got %0h want 0", load_use_hazard); end
      memwb_we = 1; memwb_rd = 5'd5; memwb_result = 32'h55;
      @(posedge clk); #1;
      memwb_we = 0; memwb_rd = 0; memwb_result = 0;
      #1;
      n_checks++; if (ex_alu_a !== 32'h55) begin n_err++; $display("FAIL lu_value: got %0h want 55", ex_alu_a); end
      n_checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd6) begin n_err++; $display("FAIL lu_capture: got v=%0h rd=%0h want 1/6", ex_valid, ex_rd); end
   endtask

   task automatic test_flush_stall();
      @(negedge clk); flush = 1; stall = 1; present(5'd1, 5'd2, 5'd7, 32'h1, 32'h2);
      @(posedge clk); #1;
      n_checks++; if (ex_valid !== 1'b0 || ex_reg_we !== 1'b0) begin n_err++; $display("FAIL flush: got v=%0h we=%0h want 0/0", ex_valid, ex_reg_we); end
      n_checks++; if (ex_alu_a !== 32'h55 || ex_rd !== 5'd6) begin n_err++; $display("FAIL flush_hold: got a=%0h rd=%0h want 55/6", ex_alu_a, ex_rd); end
      idle_inputs();
   endtask

   task automatic test_stall_retire();
      @(negedge clk); idle_inputs(); present(5'd1, 5'd7, 5'd8, 32'h1, 32'h0);
      @(posedge clk); #1;
      idle_inputs(); stall = 1;
      memwb_we = 1; memwb_rd = 5'd7; memwb_result = 32'hABCD;
      @(posedge clk); #1;
      memwb_we = 0; memwb_rd = 0; memwb_result = 0;
      #1;
      n_checks++; if (ex_alu_b !== 32'hABCD) begin n_err++; $display("FAIL stall_mid: got %0h want abcd", ex_alu_b); end
      repeat (2) @(posedge clk);
      #1; stall = 0; #1;
      n_checks++; if (ex_alu_b !== 32'hABCD) begin n_err++; $display("FAIL stall_after: got %0h want abcd", ex_alu_b); end
      n_checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd8) begin n_err++; $display("FAIL stall_hold: got v=%0h rd=%0h want 1/8", ex_valid, ex_rd); end
   endtask

   task automatic test_x0();
      @(negedge clk); idle_inputs(); present(5'd0, 5'd0, 5'd9, 32'h0, 32'h0);
      memwb_we = 1; memwb_rd = 5'd0; memwb_result = 32'hFFFF;
      @(posedge clk); #1;
      exmem_we = 1; exmem_rd = 5'd0; exmem_result = 32'h1234;
      #1;
      n_checks++; if (ex_alu_a !== 32'h0 || ex_alu_b !== 32'h0) begin n_err++; $display("FAIL x0_operand: got %0h/%0h want 0/0", ex_alu_a, ex_alu_b); end
      n_checks++; if (ex_store_data !== 32'h0) begin n_err++; $display("FAIL x0_store: got %0h want 0", ex_store_data); end
      idle_inputs();
   endtask

   task automatic test_async_reset();
      @(negedge clk); idle_inputs(); present(5'd1, 5'd2, 5'd3, 32'd5, 32'd6);
      id_pc = 32'h44;
      @(posedge clk); #1;
      stall = 1;
      @(posedge clk); #3;
      rst_n = 0; #1;
      n_checks++; if (ex_valid !== 1'b0 || ex_reg_we !== 1'b0 || ex_pc !== 32'h0) begin n_err++; $display("FAIL areset: got v=%0h we=%0h pc=%0h want 0", ex_valid, ex_reg_we, ex_pc); end
      n_checks++; if (ex_alu_a !== 32'h0 || ex_alu_b !== 32'h0 || ex_rd !== 5'd0) begin n_err++; $display("FAIL areset_data: got %0h/%0h/%0h want 0", ex_alu_a, ex_alu_b, ex_rd); end
      @(negedge clk); rst_n = 1; stall = 0; present(5'd1, 5'd2, 5'd3, 32'h77, 32'h6);
      @(posedge clk); #1;
      n_checks++; if (ex_valid !== 1'b1 || ex_alu_a !== 32'h77) begin n_err++; $display("FAIL areset_release: got v=%0h a=%0h want 1/77", ex_valid, ex_alu_a); end
      idle_inputs();
   endtask

   // Reference state: what the spec says EX should be holding.
   logic        m_valid, m_asel, m_bsel, m_we, m_re, m_wr;
   logic [31:0] m_pc, m_imm, m_v1, m_v2;
   logic [4:0]  m_rs1, m_rs2, m_rd;
   logic [3:0]  m_sel;

   function automatic logic [31:0] ref_fwd(input logic [4:0] rs, input logic [31:0] v);
      if (exmem_we && exmem_rd != 0 && exmem_rd == rs) return exmem_result;
      if (memwb_we && memwb_rd != 0 && memwb_rd == rs) return memwb_result;
      return v;
   endfunction

   task automatic test_random();
      logic [3:0]  ops [11] = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b1010, 4'b0011,
                                4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111};
      logic [31:0] e1, e2, ea, eb;
      logic        eh;
      @(negedge clk); idle_inputs(); rst_n = 0;
      @(negedge clk); rst_n = 1;
      m_valid = 0; m_asel = 0; m_bsel = 0; m_we = 0; m_re = 0; m_wr = 0;
      m_pc = 0; m_imm = 0; m_v1 = 0; m_v2 = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_sel = 0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         stall = ($urandom_range(0, 7) == 0); flush = ($urandom_range(0, 9) == 0);
         id_valid = ($urandom_range(0, 3) != 0); id_pc = $urandom; id_imm = $urandom;
         id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
         id_rd = 5'($urandom_range(0, 3)); id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom);
         id_rs1_data = $urandom; id_rs2_data = $urandom;
         id_alu_sel = ops[$urandom_range(0, 10)]; id_a_sel = 1'($urandom); id_b_sel = 1'($urandom);
         id_reg_we = 1'($urandom); id_mem_re = ($urandom_range(0, 1) == 0); id_mem_we = ($urandom_range(0, 3) == 0);
         exmem_we = 1'($urandom); exmem_rd = 5'($urandom_range(0, 3)); exmem_result = $urandom;
         memwb_we = 1'($urandom); memwb_rd = 5'($urandom_range(0, 3)); memwb_result = $urandom;
         #1;
         e1 = ref_fwd(m_rs1, m_v1); e2 = ref_fwd(m_rs2, m_v2);
         ea = m_asel ? m_pc : e1;   eb = m_bsel ? m_imm : e2;
         eh = m_valid && m_re && m_rd != 0 && id_valid && !flush &&
              ((id_use_rs1 && id_rs1 == m_rd) || (id_use_rs2 && id_rs2 == m_rd));
         n_checks++; if (load_use_hazard !== eh) begin n_err++; $display("FAIL rnd_hazard c=%0d: got %0h want %0h", c, load_use_hazard, eh); end
         n_checks++; if (ex_valid !== m_valid) begin n_err++; $display("FAIL rnd_valid c=%0d: got %0h want %0h", c, ex_valid, m_valid); end
         n_checks++; if (ex_alu_a !== ea) begin n_err++; $display("FAIL rnd_alu_a c=%0d: got %0h want %0h", c, ex_alu_a, ea); end
         n_checks++; if (ex_alu_b !== eb) begin n_err++; $display("FAIL rnd_alu_b c=%0d: got %0h want %0h", c, ex_alu_b, eb); end
         n_checks++; if (ex_store_data !== e2) begin n_err++; $display("FAIL rnd_store c=%0d: got %0h want %0h", c, ex_store_data, e2); end
         n_checks++; if ({ex_reg_we, ex_mem_re, ex_mem_we} !== {m_we, m_re, m_wr}) begin n_err++; $display("FAIL rnd_ctrl c=%0d: got %0b want %0b", c, {ex_reg_we, ex_mem_re, ex_mem_we}, {m_we, m_re, m_wr}); end
         n_checks++; if ({ex_pc, ex_imm, ex_rd, ex_alu_sel} !== {m_pc, m_imm, m_rd, m_sel}) begin n_err++; $display("FAIL rnd_fields c=%0d: got %0h want %0h", c, {ex_pc, ex_imm, ex_rd, ex_alu_sel}, {m_pc, m_imm, m_rd, m_sel}); end
         // Advance the model to what EX should hold after this edge.
         if (flush || (!stall && eh)) begin
            m_valid = 0; m_we = 0; m_re = 0; m_wr = 0;
         end else if (stall) begin
            m_v1 = e1; m_v2 = e2;
         end else begin
            m_valid = id_valid; m_pc = id_pc; m_imm = id_imm; m_rd = id_rd; m_sel = id_alu_sel;
            m_rs1 = id_rs1; m_rs2 = id_rs2; m_asel = id_a_sel; m_bsel = id_b_sel;
            m_v1 = (memwb_we && memwb_rd != 0 && memwb_rd == id_rs1) ? memwb_result : id_rs1_data;
            m_v2 = (memwb_we && memwb_rd != 0 && memwb_rd == id_rs2) ? memwb_result : id_rs2_data;
            m_we = id_valid && id_reg_we; m_re = id_valid && id_mem_re; m_wr = id_valid && id_mem_we;
         end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_capture();
      test_fwd_priority();
      test_load_use();
      test_flush_stall();
      test_stall_retire();
      test_x0();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule : tb_id_ex_stage
`default_nettype wire
